// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port ids and default timeout for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: wait counter that flags the last allowed cycle of a granted access
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (en) count <= count + 1'b1;
  assign expired = count == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) round-robin arbiter onto one memory port with timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);
  state_t state, state_nx;
  logic last_grant, lat_we, expired, i_elig, d_elig, pick_d, start, done;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0] lat_be;
  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clr(state == IDLE), .en(m_req && !m_ack), .expired(expired)
  );
  // A port is ineligible in its own ack cycle so the other side gets a turn
  always_comb begin
    i_elig = i_req && !i_ack;
    d_elig = d_req && !d_ack;
    pick_d = d_elig && (!i_elig || last_grant == PORT_I);
    start = state == IDLE && (i_elig || d_elig);
    done = state != IDLE && (m_ack || expired);
    state_nx = start ? (pick_d ? GRANT_D : GRANT_I) : done ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (rst) begin
      last_grant <= PORT_D;
      {lat_we, lat_addr, lat_wdata, lat_be} <= '0;
      {i_ack, i_err, i_rdata, d_ack, d_err, d_rdata} <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      if (start) begin
        last_grant <= pick_d ? PORT_D : PORT_I;
        lat_we <= pick_d && d_we;
        lat_addr <= pick_d ? d_addr : i_addr;
        lat_wdata <= pick_d ? d_wdata : '0;
        lat_be <= pick_d ? d_be : 4'hF;
      end
      if (done && state == GRANT_I) begin
        i_ack <= 1'b1;
        i_err <= !m_ack;
        i_rdata <= m_ack ? m_rdata : '0;
      end
      if (done && state == GRANT_D) begin
        d_ack <= 1'b1;
        d_err <= !m_ack;
        d_rdata <= (m_ack && !lat_we) ? m_rdata : '0;
      end
    end
  assign m_req = state != IDLE;
  assign m_we = m_req && lat_we;
  assign m_addr = m_req ? lat_addr : '0;
  assign m_wdata = m_req ? lat_wdata : '0;
  assign m_be = m_req ? lat_be : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for reset, contention and idle acks
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  logic i_req = 0, d_req = 0, d_we = 0, m_ack = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [3:0] d_be = 0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic i_ack, i_err, d_ack, d_err, m_req, m_we;
  logic [3:0] m_be;
  int checks = 0, errors = 0;

  mem_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // dly: grant cycles before m_ack (0 = ack in first grant cycle), 99 = never
  typedef struct {
    logic ip;
    logic [31:0] ia;
    logic dw;
    logic [31:0] da, dwd;
    logic [3:0] dbe;
    int dly;
    logic [31:0] mrd, e_rd;
    logic e_err;
    int e_g;
  } vec_t;

  vec_t vecs[7];
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0] cap_be;
  logic cap_we, got;
  int g, n;
  logic order[4];

  initial begin
    vecs[0] = '{1, 32'h100, 0, 0, 0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2};
    vecs[1] = '{0, 0, 1, 32'h200, 32'h12345678, 4'b0011, 0, 32'hAAAA5555, 32'h0, 0, 1};
    vecs[2] = '{0, 0, 0, 32'h300, 32'h0, 4'hF, 2, 32'hCAFEF00D, 32'hCAFEF00D, 0, 3};
    vecs[3] = '{0, 0, 0, 32'h340, 32'h0, 4'hF, 99, 32'h55555555, 32'h0, 1, 16};
    vecs[4] = '{0, 0, 0, 32'h380, 32'h0, 4'hF, 15, 32'h0BADC0DE, 32'h0BADC0DE, 0, 16};
    vecs[5] = '{1, 32'h140, 0, 0, 0, 0, 99, 32'h77777777, 32'h0, 1, 16};
    vecs[6] = '{1, 32'h180, 0, 0, 0, 0, 0, 32'h11223344, 32'h11223344, 0, 1};

    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_acks", {30'b0, i_ack, d_ack}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_m_be_addr", {28'b0, m_be} | m_addr, 0);

    m_ack = 1;
    @(negedge clk);
    m_ack = 0;
    chk("idle_mack_ack", {30'b0, i_ack, d_ack}, 0);
    chk("idle_mack_req", 32'(m_req), 0);

    foreach (vecs[k]) begin
      i_req = vecs[k].ip;
      i_addr = vecs[k].ia;
      d_req = !vecs[k].ip;
      d_we = vecs[k].dw;
      d_addr = vecs[k].da;
      d_wdata = vecs[k].dwd;
      d_be = vecs[k].dbe;
      m_rdata = vecs[k].mrd;
      g = 0;
      got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (i_ack || d_ack) begin
          got = 1;
          chk($sformatf("v%0d_port", k), {30'b0, i_ack, d_ack}, vecs[k].ip ? 2 : 1);
          chk($sformatf("v%0d_rdata", k), vecs[k].ip ? i_rdata : d_rdata, vecs[k].e_rd);
          chk($sformatf("v%0d_err", k), 32'(vecs[k].ip ? i_err : d_err), 32'(vecs[k].e_err));
          chk($sformatf("v%0d_cycles", k), g, vecs[k].e_g);
          chk($sformatf("v%0d_m_addr", k), cap_addr, vecs[k].ip ? vecs[k].ia : vecs[k].da);
          chk($sformatf("v%0d_m_we", k), 32'(cap_we), vecs[k].ip ? 0 : 32'(vecs[k].dw));
          chk($sformatf("v%0d_m_wdata", k), cap_wdata, vecs[k].ip ? 0 : vecs[k].dwd);
          chk($sformatf("v%0d_m_be", k), 32'(cap_be), vecs[k].ip ? 32'hF : 32'(vecs[k].dbe));
          chk($sformatf("v%0d_m_req_after", k), 32'(m_req), 0);
        end else if (m_req) begin
          g++;
          {cap_addr, cap_we, cap_wdata, cap_be} = {m_addr, m_we, m_wdata, m_be};
          m_ack = g == vecs[k].dly + 1;
          if (g == 1) begin
            i_addr ^= 32'hFFFF0000;
            d_addr ^= 32'hFFFF0000;
            d_wdata ^= 32'h0F0F0F0F;
            d_be ^= 4'hC;
          end
        end else m_ack = 0;
      end
      if (!got) chk($sformatf("v%0d_ack_seen", k), 0, 1);
      i_req = 0;
      d_req = 0;
      m_ack = 0;
      @(negedge clk);
      chk($sformatf("v%0d_single_ack", k), {30'b0, i_ack, d_ack}, 0);
    end

    chk("hold_i_rdata", i_rdata, 32'h11223344);
    chk("hold_i_err", 32'(i_err), 0);
    chk("hold_d_rdata", d_rdata, 32'h0BADC0DE);
    chk("hold_d_err", 32'(d_err), 0);

    i_req = 1;
    i_addr = 32'h400;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      got = m_req;
    end
    chk("rstmid_granted", 32'(got), 1);
    rst = 1;
    m_ack = 1;
    m_rdata = 32'h99999999;
    @(negedge clk);
    rst = 0;
    m_ack = 0;
    i_req = 0;
    chk("rstmid_m_req", 32'(m_req), 0);
    chk("rstmid_no_ack", {30'b0, i_ack, d_ack}, 0);
    @(negedge clk);
    chk("rstmid_no_ack2", {30'b0, i_ack, d_ack}, 0);

    i_req = 1;
    d_req = 1;
    d_we = 0;
    d_addr = 32'h500;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (i_ack && d_ack) chk("both_acks", 1, 0);
      if (i_ack || d_ack) begin
        order[n] = d_ack;
        n++;
      end
      m_ack = m_req;
    end
    i_req = 0;
    d_req = 0;
    m_ack = 0;
    chk("rr_count", n, 4);
    for (int j = 0; j < 4; j++) chk($sformatf("rr_order%0d", j), 32'(order[j]), 32'(j % 2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
